// File: rtl/dram_arbiter.sv
// dram_arbiter: arbitrates one single-port data DRAM between the core
// load/store port and the host loader port. One word per transaction.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   core_req/we/addr/wdata_i      core request and operands
//   core_gnt_o, core_done_o       core ownership and completion pulse
//   host_req/we/addr/wdata_i      host request and operands
//   host_gnt_o, host_done_o       host ownership and completion pulse
//   rdata_o                       last completed read data (shared)
//   mem_en/we/addr/wdata_o        DRAM strobe and operands
//   mem_rdata_i                   DRAM read data, RD_LAT after mem_en
//   busy_o                        transaction in progress
module dram_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 12,
   parameter int RD_LAT    = 2,
   parameter int CORE_PRIO = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_done_o,
   input  logic              host_req_i,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_gnt_o,
   output logic              host_done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int LAT_W = $clog2(RD_LAT + 1);
   localparam bit RR    = (CORE_PRIO == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e            state_q;
   logic              last_host_q;
   logic              own_host_q;
   logic [LAT_W-1:0]  lat_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              core_gnt_q;
   logic              core_done_q;
   logic              host_gnt_q;
   logic              host_done_q;
   logic              pick_host_d;

   // On a tie, round-robin hands the DRAM to whoever was not served last.
   always_comb begin
      pick_host_d = host_req_i;
      if (core_req_i && host_req_i) begin
         pick_host_d = RR && !last_host_q;
      end
   end

   // The mem_* registers double as the latched operand copy; they are
   // cleared after the strobe so the DRAM bus idles at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         last_host_q <= 1'b1;
         own_host_q  <= 1'b0;
         lat_q       <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_gnt_q  <= 1'b0;
         core_done_q <= 1'b0;
         host_gnt_q  <= 1'b0;
         host_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (core_req_i || host_req_i) begin
                  state_q     <= S_ISSUE;
                  own_host_q  <= pick_host_d;
                  last_host_q <= pick_host_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= pick_host_d ? host_we_i : core_we_i;
                  mem_addr_q  <= pick_host_d ? host_addr_i : core_addr_i;
                  mem_wdata_q <= pick_host_d ? host_wdata_i : core_wdata_i;
                  core_gnt_q  <= !pick_host_d;
                  host_gnt_q  <= pick_host_d;
               end
            end
            S_ISSUE: begin
               mem_en_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               if (mem_we_q) begin
                  state_q     <= S_DONE;
                  core_done_q <= !own_host_q;
                  host_done_q <= own_host_q;
               end else begin
                  lat_q   <= LAT_W'(RD_LAT - 1);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_q == '0) begin
                  rdata_q     <= mem_rdata_i;
                  state_q     <= S_DONE;
                  core_done_q <= !own_host_q;
                  host_done_q <= own_host_q;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               core_gnt_q  <= 1'b0;
               host_gnt_q  <= 1'b0;
               core_done_q <= 1'b0;
               host_done_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign core_gnt_o  = core_gnt_q;
   assign core_done_o = core_done_q;
   assign host_gnt_o  = host_gnt_q;
   assign host_done_o = host_done_q;
   assign rdata_o     = rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scenario tasks with a transaction scoreboard for the
// DRAM arbiter; a second instance covers the fixed core-priority mode.
module tb_dram_arbiter;

   localparam int AW     = 12;
   localparam int DW     = 12;
   localparam int RD_LAT = 2;

   typedef struct {
      bit          host;
      bit          we;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          core_req = 1'b0;
   logic          core_we = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          host_req = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;

   logic          core_gnt, core_done, host_gnt, host_done;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   logic          core_gnt_p, core_done_p, host_gnt_p, host_done_p;
   logic [DW-1:0] rdata_p;
   logic          mem_en_p, mem_we_p;
   logic [AW-1:0] mem_addr_p;
   logic [DW-1:0] mem_wdata_p;
   logic          busy_p;

   int n_vec = 0;
   int n_err = 0;

   exp_t          sb[$];
   logic [DW-1:0] ref_mem [int];

   logic [DW-1:0] dram [0:(1<<AW)-1];
   logic [DW-1:0] pipe [RD_LAT];

   always #5 clk = ~clk;

   dram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CORE_PRIO(0)
   ) u_rr (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_we_i(core_we),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata),
      .core_gnt_o(core_gnt), .core_done_o(core_done),
      .host_req_i(host_req), .host_we_i(host_we),
      .host_addr_i(host_addr), .host_wdata_i(host_wdata),
      .host_gnt_o(host_gnt), .host_done_o(host_done),
      .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   dram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CORE_PRIO(1)
   ) u_cp (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_we_i(core_we),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata),
      .core_gnt_o(core_gnt_p), .core_done_o(core_done_p),
      .host_req_i(host_req), .host_we_i(host_we),
      .host_addr_i(host_addr), .host_wdata_i(host_wdata),
      .host_gnt_o(host_gnt_p), .host_done_o(host_done_p),
      .rdata_o(rdata_p), .mem_en_o(mem_en_p), .mem_we_o(mem_we_p),
      .mem_addr_o(mem_addr_p), .mem_wdata_o(mem_wdata_p),
      .mem_rdata_i(mem_rdata), .busy_o(busy_p)
   );

   // DRAM model: write on strobe, read data appears RD_LAT cycles later.
   always @(posedge clk) begin
      if (mem_en && mem_we) dram[mem_addr] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? dram[mem_addr] : 12'hBAD;
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({core_gnt, core_done, host_gnt, host_done, mem_en, mem_we,
           mem_addr, mem_wdata, rdata, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_rr gnt/done=%b%b%b%b en=%b busy=%b rdata=%h required all 0",
                  core_gnt, core_done, host_gnt, host_done, mem_en, busy, rdata);
      end
      n_vec++;
      if ({core_gnt_p, core_done_p, host_gnt_p, host_done_p, mem_en_p,
           mem_we_p, mem_addr_p, mem_wdata_p, rdata_p, busy_p} !== '0) begin
         n_err++;
         $display("FAIL reset_cp en=%b busy=%b rdata=%h required all 0",
                  mem_en_p, busy_p, rdata_p);
      end
      tick();
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         n_vec++;
         if ({mem_en, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_quiet mem_en=%b busy=%b required 0 0",
                     mem_en, busy);
         end
      end
   endtask

   task automatic test_core_write();
      exp_t e;
      tick();
      core_req = 1'b1; core_we = 1'b1;
      core_addr = 12'h005; core_wdata = 12'h0AB;
      ref_mem[12'h005] = 12'h0AB;
      sb.push_back('{host: 1'b0, we: 1'b1, data: 12'h0AB});
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, core_gnt, host_gnt} !==
          {1'b1, 1'b1, 12'h005, 12'h0AB, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL wr_strobe en=%b we=%b addr=%h wdata=%h cg=%b hg=%b required 1 1 005 0ab 1 0",
                  mem_en, mem_we, mem_addr, mem_wdata, core_gnt, host_gnt);
      end
      @(negedge clk);
      n_vec++;
      if ({core_done, host_done, mem_en} !== 3'b100) begin
         n_err++;
         $display("FAIL wr_done cd=%b hd=%b en=%b required 1 0 0",
                  core_done, host_done, mem_en);
      end
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL wr_sb queue empty, required one entry");
      end else begin
         e = sb.pop_front();
         if (host_done !== e.host) begin
            n_err++;
            $display("FAIL wr_sb_owner host_done=%b required %b", host_done, e.host);
         end
      end
      tick();
      core_req = 1'b0;
   endtask

   task automatic test_host_read();
      exp_t e;
      tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 12'h005;
      sb.push_back('{host: 1'b1, we: 1'b0, data: ref_mem[12'h005]});
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({mem_en, mem_we, mem_addr, host_gnt, core_gnt} !==
          {1'b1, 1'b0, 12'h005, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL rd_strobe en=%b we=%b addr=%h hg=%b cg=%b required 1 0 005 1 0",
                  mem_en, mem_we, mem_addr, host_gnt, core_gnt);
      end
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if ({host_done, core_gnt, mem_en, host_gnt} !== 4'b0001) begin
            n_err++;
            $display("FAIL rd_wait hd=%b cg=%b en=%b hg=%b required 0 0 0 1",
                     host_done, core_gnt, mem_en, host_gnt);
         end
      end
      @(negedge clk);
      n_vec++;
      if ({host_done, core_done, core_gnt} !== 3'b100) begin
         n_err++;
         $display("FAIL rd_done hd=%b cd=%b cg=%b required 1 0 0",
                  host_done, core_done, core_gnt);
      end
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL rd_sb queue empty, required one entry");
      end else begin
         e = sb.pop_front();
         if (host_done !== e.host || rdata !== e.data) begin
            n_err++;
            $display("FAIL rd_sb host_done=%b rdata=%h required %b %h",
                     host_done, rdata, e.host, e.data);
         end
      end
      tick();
      host_req = 1'b0;
   endtask

   task automatic test_tie();
      bit q0[$];
      bit q1[$];
      bit x;
      int got0 = 0;
      int got1 = 0;
      tick();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      core_req = 1'b1; core_we = 1'b1;
      core_addr = 12'h010; core_wdata = 12'h111;
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 12'h020; host_wdata = 12'h222;
      ref_mem[12'h010] = 12'h111;
      ref_mem[12'h020] = 12'h222;
      q0 = '{1'b0, 1'b1, 1'b0};
      q1 = '{1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 40 && (got0 < 3 || got1 < 3); c++) begin
         @(negedge clk);
         if ((core_done || host_done) && got0 < 3) begin
            x = q0.pop_front();
            got0++;
            n_vec++;
            if (host_done !== x || core_done === host_done) begin
               n_err++;
               $display("FAIL tie_rr grant %0d host_done=%b core_done=%b required host=%b",
                        got0, host_done, core_done, x);
            end
         end
         if ((core_done_p || host_done_p) && got1 < 3) begin
            x = q1.pop_front();
            got1++;
            n_vec++;
            if (host_done_p !== x || core_done_p === host_done_p) begin
               n_err++;
               $display("FAIL tie_prio grant %0d host_done=%b core_done=%b required host=%b",
                        got1, host_done_p, core_done_p, x);
            end
         end
      end
      n_vec++;
      if (got0 < 3 || got1 < 3) begin
         n_err++;
         $display("FAIL tie_timeout rr=%0d prio=%0d completions, required 3 3",
                  got0, got1);
      end
      tick();
      core_req = 1'b0;
      host_req = 1'b0;
   endtask

   task automatic test_wait_hold();
      exp_t e;
      bit seen = 1'b0;
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 12'h020;
      sb.push_back('{host: 1'b0, we: 1'b0, data: ref_mem[12'h020]});
      @(negedge clk);
      @(negedge clk);
      tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
      sb.push_back('{host: 1'b1, we: 1'b0, data: ref_mem[12'h010]});
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if ({host_gnt, core_gnt} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_wait hg=%b cg=%b required 0 1", host_gnt, core_gnt);
         end
      end
      @(negedge clk);
      n_vec++;
      if ({core_done, host_gnt} !== 2'b10) begin
         n_err++;
         $display("FAIL hold_cdone cd=%b hg=%b required 1 0", core_done, host_gnt);
      end
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL hold_sb1 queue empty, required one entry");
      end else begin
         e = sb.pop_front();
         if (host_done !== e.host || rdata !== e.data) begin
            n_err++;
            $display("FAIL hold_sb1 host_done=%b rdata=%h required %b %h",
                     host_done, rdata, e.host, e.data);
         end
      end
      tick();
      core_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({host_gnt, busy, rdata} !== {1'b0, 1'b0, 12'h222}) begin
         n_err++;
         $display("FAIL hold_gap hg=%b busy=%b rdata=%h required 0 0 222",
                  host_gnt, busy, rdata);
      end
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (host_done || core_done) begin
            seen = 1'b1;
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL hold_sb2 queue empty, required one entry");
            end else begin
               e = sb.pop_front();
               if (host_done !== e.host || rdata !== e.data) begin
                  n_err++;
                  $display("FAIL hold_sb2 host_done=%b rdata=%h required %b %h",
                           host_done, rdata, e.host, e.data);
               end
            end
         end
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL hold_timeout host_done=0 required 1 within 20 cycles");
      end
      tick();
      host_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int got = 0;
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 12'h005;
      @(negedge clk);
      @(negedge clk);
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre busy=%b required 1", busy);
      end
      tick();
      rst = 1'b0;
      core_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({core_gnt, core_done, host_gnt, host_done, mem_en, busy, rdata} !== '0) begin
         n_err++;
         $display("FAIL rstmid_post cg=%b cd=%b en=%b busy=%b rdata=%h required 0 0 0 0 000",
                  core_gnt, core_done, mem_en, busy, rdata);
      end
      repeat (5) begin
         @(negedge clk);
         n_vec++;
         if ({core_done, host_done} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_nodone cd=%b hd=%b required 0 0",
                     core_done, host_done);
         end
      end
      tick();
      core_req = 1'b1; core_we = 1'b1;
      core_addr = 12'h030; core_wdata = 12'h333;
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 12'h040; host_wdata = 12'h444;
      sb.push_back('{host: 1'b0, we: 1'b1, data: 12'h333});
      sb.push_back('{host: 1'b1, we: 1'b1, data: 12'h444});
      for (int c = 0; c < 30 && got < 2; c++) begin
         @(negedge clk);
         if (core_done || host_done) begin
            got++;
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rstmid_sb queue empty, required entry");
            end else begin
               e = sb.pop_front();
               if (host_done !== e.host) begin
                  n_err++;
                  $display("FAIL rstmid_tie grant %0d host_done=%b required %b",
                           got, host_done, e.host);
               end
            end
            tick();
            if (got == 1) core_req = 1'b0;
            else host_req = 1'b0;
         end
      end
      n_vec++;
      if (got < 2) begin
         n_err++;
         $display("FAIL rstmid_timeout completions=%0d required 2", got);
      end
   endtask

   initial begin
      test_reset();
      test_core_write();
      test_host_read();
      test_tie();
      test_wait_hold();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, required finish before 100000");
      $fatal(1);
   end

endmodule
